data_sram_responder: RTL and testbench

- Memory-side counterpart to the EX-stage data request path.
- Accepts the single-cycle data request that EX drives (req, byte write enables, address, write data, plus access size) and runs it as a two-phase SRAM-like transaction: request/addr_ok, then data_ok/rdata.
- Returns the read data or write completion to the MEM stage.
- Drives the stall signal that EX uses as its mem stall input, and handles exception flush of in-flight accesses.

---
 rtl/data_sram_responder.sv | 178 +++++++++++++++++
 tb/tb_data_sram_responder.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_responder.sv
// Memory-side responder: turns a single-cycle EX data request into an SRAM-like
// addr_ok/data_ok transaction and hands the result to MEM. Optional macro: DATA_RESP_BUF_EN.
module data_sram_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_req_i,
    input  logic [3:0]            ex_we_i,
    input  logic [1:0]            ex_size_i,
    input  logic [ADDR_WIDTH-1:0] ex_addr_i,
    input  logic [DATA_WIDTH-1:0] ex_wdata_i,
    input  logic                  excep_flush_i,
    input  logic                  mem_allowin_i,
    output logic                  mem_stall_o,
    output logic                  resp_valid_o,
    output logic                  resp_is_write_o,
    output logic [DATA_WIDTH-1:0] resp_rdata_o,
    output logic                  data_req_o,
    output logic                  data_wr_o,
    output logic [1:0]            data_size_o,
    output logic [3:0]            data_wstrb_o,
    output logic [ADDR_WIDTH-1:0] data_addr_o,
    output logic [DATA_WIDTH-1:0] data_wdata_o,
    input  logic                  data_addr_ok_i,
    input  logic                  data_data_ok_i,
    input  logic [DATA_WIDTH-1:0] data_rdata_i
);

    if (DATA_WIDTH != 32) begin : g_width_check
        $error("data_sram_responder requires DATA_WIDTH == 32");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_CANCEL,
        S_HOLD
    } state_e;

    state_e                  state_q, state_d;
    logic                    cancel_q, cancel_d;
    logic                    wr_q, wr_d;
    logic [1:0]              size_q, size_d;
    logic [3:0]              wstrb_q, wstrb_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    resp_is_write_q, resp_is_write_d;
    logic [DATA_WIDTH-1:0]   resp_rdata_q, resp_rdata_d;
    logic                    accept;

`ifdef DATA_RESP_BUF_EN
    logic                    buf_vld_q, buf_vld_d;

    // A full buffer only blocks a new request if MEM is not draining it this cycle.
    assign accept       = ex_req_i && !excep_flush_i && !(buf_vld_q && !mem_allowin_i);
    assign mem_stall_o  = (state_q != S_IDLE) || (buf_vld_q && !mem_allowin_i);
    assign resp_valid_o = buf_vld_q;
`else
    assign accept       = ex_req_i && !excep_flush_i;
    assign mem_stall_o  = (state_q != S_IDLE);
    assign resp_valid_o = (state_q == S_HOLD);
`endif

    assign data_req_o      = (state_q == S_ADDR);
    assign data_wr_o       = wr_q;
    assign data_size_o     = size_q;
    assign data_wstrb_o    = wstrb_q;
    assign data_addr_o     = addr_q;
    assign data_wdata_o    = wdata_q;
    assign resp_is_write_o = resp_is_write_q;
    assign resp_rdata_o    = resp_rdata_q;

    always_comb begin
        state_d         = state_q;
        cancel_d        = cancel_q;
        wr_d            = wr_q;
        size_d          = size_q;
        wstrb_d         = wstrb_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        resp_is_write_d = resp_is_write_q;
        resp_rdata_d    = resp_rdata_q;
`ifdef DATA_RESP_BUF_EN
        buf_vld_d       = buf_vld_q;
        if (buf_vld_q && (mem_allowin_i || excep_flush_i)) begin
            buf_vld_d = 1'b0;
        end
`endif

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    wr_d     = |ex_we_i;
                    size_d   = ex_size_i;
                    wstrb_d  = ex_we_i;
                    addr_d   = ex_addr_i;
                    wdata_d  = ex_wdata_i;
                    cancel_d = 1'b0;
                    state_d  = S_ADDR;
                end
            end
            S_ADDR: begin
                // The request stays up until accepted; a flush only marks it for discard.
                if (data_addr_ok_i) begin
                    state_d  = (cancel_q || excep_flush_i) ? S_CANCEL : S_WAIT;
                    cancel_d = 1'b0;
                end else if (excep_flush_i) begin
                    cancel_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (data_data_ok_i) begin
                    if (excep_flush_i) begin
                        state_d = S_IDLE;
                    end else begin
                        resp_is_write_d = wr_q;
                        resp_rdata_d    = wr_q ? '0 : data_rdata_i;
`ifdef DATA_RESP_BUF_EN
                        buf_vld_d       = 1'b1;
                        state_d         = S_IDLE;
`else
                        state_d         = S_HOLD;
`endif
                    end
                end else if (excep_flush_i) begin
                    state_d = S_CANCEL;
                end
            end
            S_CANCEL: begin
                if (data_data_ok_i) begin
                    state_d = S_IDLE;
                end
            end
            S_HOLD: begin
                if (mem_allowin_i || excep_flush_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            cancel_q        <= 1'b0;
            wr_q            <= 1'b0;
            size_q          <= 2'b00;
            wstrb_q         <= 4'b0000;
            addr_q          <= '0;
            wdata_q         <= '0;
            resp_is_write_q <= 1'b0;
            resp_rdata_q    <= '0;
`ifdef DATA_RESP_BUF_EN
            buf_vld_q       <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            cancel_q        <= cancel_d;
            wr_q            <= wr_d;
            size_q          <= size_d;
            wstrb_q         <= wstrb_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            resp_is_write_q <= resp_is_write_d;
            resp_rdata_q    <= resp_rdata_d;
`ifdef DATA_RESP_BUF_EN
            buf_vld_q       <= buf_vld_d;
`endif
        end
    end

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: directed timing scenarios plus randomized traffic
// against a word-array reference model, checked by a response scoreboard.
module tb_data_sram_responder;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ex_req_i = 1'b0;
    logic [3:0]    ex_we_i = 4'b0;
    logic [1:0]    ex_size_i = 2'b0;
    logic [AW-1:0] ex_addr_i = '0;
    logic [DW-1:0] ex_wdata_i = '0;
    logic          excep_flush_i = 1'b0;
    logic          mem_allowin_i = 1'b0;
    logic          mem_stall_o, resp_valid_o, resp_is_write_o;
    logic [DW-1:0] resp_rdata_o;
    logic          data_req_o, data_wr_o;
    logic [1:0]    data_size_o;
    logic [3:0]    data_wstrb_o;
    logic [AW-1:0] data_addr_o;
    logic [DW-1:0] data_wdata_o;
    logic          data_addr_ok_i = 1'b0;
    logic          data_data_ok_i = 1'b0;
    logic [DW-1:0] data_rdata_i = '0;

    data_sram_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .ex_req_i(ex_req_i), .ex_we_i(ex_we_i), .ex_size_i(ex_size_i),
        .ex_addr_i(ex_addr_i), .ex_wdata_i(ex_wdata_i),
        .excep_flush_i(excep_flush_i), .mem_allowin_i(mem_allowin_i),
        .mem_stall_o(mem_stall_o), .resp_valid_o(resp_valid_o),
        .resp_is_write_o(resp_is_write_o), .resp_rdata_o(resp_rdata_o),
        .data_req_o(data_req_o), .data_wr_o(data_wr_o), .data_size_o(data_size_o),
        .data_wstrb_o(data_wstrb_o), .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
        .data_addr_ok_i(data_addr_ok_i), .data_data_ok_i(data_data_ok_i),
        .data_rdata_i(data_rdata_i)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit stuck = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Reference model: one word per index, indexed by address bits [5:2].
    typedef struct packed {
        logic        wr;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] ref_mem [16];
    logic [31:0] bus_mem [16];
    logic [31:0] acc_addr = '0, acc_wdata = '0;
    logic [3:0]  acc_we = '0;
    logic [1:0]  acc_size = '0;
    int          resp_cnt = 0;
    int          m_idx;
    exp_t        m_e;

    // Bus slave and MEM consumer knobs.
    int          addr_dly = 0, data_dly = 0, allow_mode = 1;
    bit          rand_dly = 0;
    int          a_cnt = 0, d_cnt = 0, s_idx;
    bit          a_busy = 0, d_pend = 0;
    logic [31:0] d_rdata = '0;

    always begin
        @(negedge clk);
        #1;
        data_addr_ok_i = 1'b0;
        data_data_ok_i = 1'b0;
        data_rdata_i   = $urandom;
        if (d_pend) begin
            if (d_cnt == 0) begin
                data_data_ok_i = 1'b1;
                data_rdata_i   = d_rdata;
                d_pend         = 0;
            end else begin
                d_cnt--;
            end
        end
        if (data_req_o !== 1'b1) begin
            a_busy = 0;
        end else begin
            if (!a_busy) begin
                a_busy = 1;
                a_cnt  = rand_dly ? int'($urandom_range(0, 3)) : addr_dly;
            end
            if (a_cnt == 0) begin
                data_addr_ok_i = 1'b1;
                a_busy = 0;
                d_pend = 1;
                d_cnt  = rand_dly ? int'($urandom_range(0, 3)) : data_dly;
                s_idx  = int'(data_addr_o[5:2]);
                d_rdata = data_wr_o ? $urandom : bus_mem[s_idx];
                if (data_wr_o) begin
                    for (int b = 0; b < 4; b++)
                        if (data_wstrb_o[b]) bus_mem[s_idx][8*b +: 8] = data_wdata_o[8*b +: 8];
                end
            end else begin
                a_cnt--;
            end
        end
        case (allow_mode)
            0:       mem_allowin_i = 1'b0;
            1:       mem_allowin_i = 1'b1;
            default: mem_allowin_i = 1'($urandom_range(0, 1));
        endcase
    end

    // Scoreboard monitor: evaluates what the coming clock edge will do.
    always begin
        @(negedge clk);
        #2;
        if (rst) begin
            sb_q.delete();
        end else begin
            if (resp_valid_o === 1'b1) begin
                if (sb_q.size() == 0) begin
                    fail("unexpected_resp");
                end else begin
                    chk("resp_is_write", resp_is_write_o, sb_q[0].wr);
                    chk("resp_rdata", resp_rdata_o, sb_q[0].rdata);
                end
            end
            if (excep_flush_i) begin
                sb_q.delete();
            end else if (resp_valid_o === 1'b1 && mem_allowin_i && sb_q.size() != 0) begin
                void'(sb_q.pop_front());
                resp_cnt++;
            end
            if (data_req_o === 1'b1 && data_addr_ok_i) begin
                chk("bus_addr", data_addr_o, acc_addr);
                chk("bus_wr", data_wr_o, |acc_we);
                chk("bus_wstrb", data_wstrb_o, acc_we);
                chk("bus_size", data_size_o, acc_size);
                chk("bus_wdata", data_wdata_o, acc_wdata);
            end
            if (ex_req_i && !excep_flush_i && mem_stall_o === 1'b0) begin
                acc_addr  = ex_addr_i;
                acc_we    = ex_we_i;
                acc_size  = ex_size_i;
                acc_wdata = ex_wdata_i;
                m_idx     = int'(ex_addr_i[5:2]);
                m_e.wr    = |ex_we_i;
                if (|ex_we_i) begin
                    m_e.rdata = 32'h0;
                    for (int b = 0; b < 4; b++)
                        if (ex_we_i[b]) ref_mem[m_idx][8*b +: 8] = ex_wdata_i[8*b +: 8];
                end else begin
                    m_e.rdata = ref_mem[m_idx];
                end
                sb_q.push_back(m_e);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        ex_req_i      = 1'b0;
        excep_flush_i = 1'b0;
    endtask

    task automatic issue(input logic [3:0] we, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd);
        ex_req_i   = 1'b1;
        ex_we_i    = we;
        ex_size_i  = sz;
        ex_addr_i  = a;
        ex_wdata_i = wd;
    endtask

    task automatic wait_idle(input bit rand_flush);
        int n = 0;
        while (mem_stall_o !== 1'b0 && n < 200) begin
            if (rand_flush && $urandom_range(0, 15) == 0) excep_flush_i = 1'b1;
            step();
            n++;
        end
        if (n >= 200) begin
            fail("idle_timeout");
            stuck = 1;
        end
    endtask

    task automatic chk_zero(input string p);
        chk({p, "_data_req"}, data_req_o, 0);
        chk({p, "_data_wr"}, data_wr_o, 0);
        chk({p, "_data_size"}, data_size_o, 0);
        chk({p, "_data_wstrb"}, data_wstrb_o, 0);
        chk({p, "_data_addr"}, data_addr_o, 0);
        chk({p, "_data_wdata"}, data_wdata_o, 0);
        chk({p, "_resp_valid"}, resp_valid_o, 0);
        chk({p, "_resp_is_write"}, resp_is_write_o, 0);
        chk({p, "_resp_rdata"}, resp_rdata_o, 0);
        chk({p, "_mem_stall"}, mem_stall_o, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = $urandom;
            bus_mem[i] = ref_mem[i];
        end
        ref_mem[4] = 32'hDEADBEEF;
        bus_mem[4] = 32'hDEADBEEF;

        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        step();

        // Word read at minimum latency.
        wait_idle(0);
        addr_dly = 0; data_dly = 0; allow_mode = 1;
        issue(4'b0000, 2'd2, 32'h1C00_0010, 32'h0);
        step();
        chk("rd_req_c1", data_req_o, 1);
        chk("rd_stall_c1", mem_stall_o, 1);
        step();
        chk("rd_req_c2", data_req_o, 0);
        chk("rd_stall_c2", mem_stall_o, 1);
        step();
        chk("rd_valid_c3", resp_valid_o, 1);
        chk("rd_rdata_c3", resp_rdata_o, 32'hDEADBEEF);
        chk("rd_stall_c3", mem_stall_o, 1);
        step();
        chk("rd_stall_c4", mem_stall_o, 0);
        chk("rd_valid_c4", resp_valid_o, 0);

        // Byte write with addr_ok delayed.
        wait_idle(0);
        addr_dly = 2; data_dly = 0;
        issue(4'b0100, 2'd0, 32'h0000_0002, 32'h5A5A_5A5A);
        for (int c = 1; c <= 3; c++) begin
            step();
            chk("wr_req_held", data_req_o, 1);
            chk("wr_bus_wr", data_wr_o, 1);
            chk("wr_bus_size", data_size_o, 0);
            chk("wr_bus_wstrb", data_wstrb_o, 4'b0100);
            chk("wr_bus_addr", data_addr_o, 32'h2);
            chk("wr_bus_wdata", data_wdata_o, 32'h5A5A_5A5A);
        end
        step();
        chk("wr_req_c4", data_req_o, 0);
        step();
        chk("wr_valid_c5", resp_valid_o, 1);
        chk("wr_is_write_c5", resp_is_write_o, 1);
        chk("wr_rdata_c5", resp_rdata_o, 0);

        // Flush while in the address phase.
        wait_idle(0);
        addr_dly = 2; data_dly = 1;
        issue(4'b0000, 2'd2, 32'h1C00_0020, 32'h0);
        step();
        chk("fl_req_c1", data_req_o, 1);
        step();
        chk("fl_req_c2", data_req_o, 1);
        excep_flush_i = 1'b1;
        step();
        chk("fl_req_c3", data_req_o, 1);
        chk("fl_valid_c3", resp_valid_o, 0);
        step();
        chk("fl_req_c4", data_req_o, 0);
        chk("fl_valid_c4", resp_valid_o, 0);
        chk("fl_stall_c4", mem_stall_o, 1);
        step();
        chk("fl_valid_c5", resp_valid_o, 0);
        chk("fl_stall_c5", mem_stall_o, 1);
        step();
        chk("fl_stall_c6", mem_stall_o, 0);
        chk("fl_valid_c6", resp_valid_o, 0);

        // MEM backpressure in HOLD; a request meanwhile must be ignored.
        wait_idle(0);
        addr_dly = 0; data_dly = 0; allow_mode = 0;
        issue(4'b0000, 2'd2, 32'h1C00_0010, 32'h0);
        step();
        step();
        for (int c = 3; c <= 6; c++) begin
            step();
            chk("bp_valid", resp_valid_o, 1);
            chk("bp_rdata", resp_rdata_o, 32'hDEADBEEF);
            chk("bp_stall", mem_stall_o, 1);
            if (c >= 5) chk("bp_no_req", data_req_o, 0);
            if (c == 4) issue(4'b0000, 2'd2, 32'h1C00_0030, 32'h0);
            if (c == 6) allow_mode = 1;
        end
        step();
        chk("bp_stall_c7", mem_stall_o, 0);
        chk("bp_valid_c7", resp_valid_o, 0);
        chk("bp_req_c7", data_req_o, 0);

        // Reset during WAIT, then a stray data_ok for the lost transaction.
        wait_idle(0);
        addr_dly = 0; data_dly = 2;
        issue(4'b0000, 2'd2, 32'h1C00_0010, 32'h0);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_zero("rst_wait");
        for (int c = 4; c <= 6; c++) begin
            step();
            chk("rst_stray_valid", resp_valid_o, 0);
            chk("rst_stray_stall", mem_stall_o, 0);
        end

        // Randomized traffic with random bus delays, backpressure and flushes.
        rand_dly = 1; allow_mode = 2;
        for (int n = 0; n < 300 && !stuck; n++) begin
            wait_idle(1);
            if ($urandom_range(0, 3) == 0) begin
                step();
            end else begin
                issue(($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(1, 15)),
                      2'($urandom_range(0, 2)), $urandom, $urandom);
                if ($urandom_range(0, 15) == 0) excep_flush_i = 1'b1;
                step();
            end
        end

        allow_mode = 1;
        wait_idle(0);
        repeat (4) step();
        chk("sb_drained", sb_q.size(), 0);
        chk("resp_seen", (resp_cnt > 20) ? 1 : 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
